// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master between N_REQ requesters, with per-device select routing.
// Optional WAIT-state watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter #(
   parameter int unsigned N_REQ       = 5,
   parameter int unsigned GAP_CYC     = 4,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [16*N_REQ-1:0]  req_data,
   output logic [N_REQ-1:0]     gnt,
   output logic [N_REQ-1:0]     req_done,
   output logic [15:0]          rd_data,
   output logic                 spi_wrt,
   output logic [15:0]          spi_data_out,
   input  logic                 spi_done,
   input  logic [15:0]          spi_data_in,
   input  logic                 spi_ss_n_in,
   output logic [N_REQ-1:0]     ss_n,
   output logic                 busy,
   input  logic                 clr_err,
   output logic                 err_timeout
);

   localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [2:0] {StIdle, StGrant, StLaunch, StWait, StGap} state_e;

   state_e          state_q;
   logic [IW-1:0]   owner_q;
   logic [IW-1:0]   rr_ptr_q;
   logic [7:0]      gap_cnt_q;
   logic [IW-1:0]   pick;
   logic            pick_vld;
   logic [N_REQ-1:0] one_hot_base;
   int unsigned     idx;

   assign one_hot_base = {{(N_REQ-1){1'b0}}, 1'b1};

   // Descending scan so the lowest offset from rr_ptr_q wins.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      idx      = 0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = (int'(rr_ptr_q) + i) % N_REQ;
         if (req[idx]) begin
            pick     = IW'(idx);
            pick_vld = 1'b1;
         end
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   logic [31:0] tmo_cnt_q;
`else
   logic unused_clr_err;
   assign unused_clr_err = clr_err;
   assign err_timeout    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         owner_q      <= '0;
         rr_ptr_q     <= '0;
         gap_cnt_q    <= '0;
         gnt          <= '0;
         req_done     <= '0;
         rd_data      <= '0;
         spi_wrt      <= 1'b0;
         spi_data_out <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
         tmo_cnt_q    <= '0;
         err_timeout  <= 1'b0;
`endif
      end else begin
         req_done <= '0;
         spi_wrt  <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
         if (clr_err) err_timeout <= 1'b0;
         if (state_q == StLaunch || state_q == StWait) tmo_cnt_q <= tmo_cnt_q + 32'd1;
`endif
         case (state_q)
            StIdle: begin
               if (pick_vld) begin
                  owner_q      <= pick;
                  gnt          <= one_hot_base << pick;
                  spi_data_out <= req_data[16*int'(pick) +: 16];
                  state_q      <= StGrant;
               end
            end
            StGrant: begin
               spi_wrt <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
               tmo_cnt_q <= '0;
`endif
               state_q <= StLaunch;
            end
            StLaunch: state_q <= StWait;
            StWait: begin
               if (spi_done) begin
                  rd_data   <= spi_data_in;
                  req_done  <= gnt;
                  gnt       <= '0;
                  rr_ptr_q  <= (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                  gap_cnt_q <= 8'(GAP_CYC);
                  state_q   <= StGap;
               end
`ifdef SPI_ARB_TIMEOUT_EN
               else if (tmo_cnt_q == TIMEOUT_CYC - 1) begin
                  // Setting overrides a clr_err in the same cycle.
                  err_timeout <= 1'b1;
                  rd_data     <= 16'hFFFF;
                  req_done    <= gnt;
                  gnt         <= '0;
                  rr_ptr_q    <= (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                  gap_cnt_q   <= 8'(GAP_CYC);
                  state_q     <= StGap;
               end
`endif
            end
            StGap: begin
               gap_cnt_q <= gap_cnt_q - 8'd1;
               if (gap_cnt_q <= 8'd1) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Only the owner's select follows the master; gnt is one-hot so at most one bit is low.
   assign ss_n = (state_q == StGrant || state_q == StLaunch || state_q == StWait) ?
                 (~gnt | {N_REQ{spi_ss_n_in}}) : '1;
   assign busy = (state_q != StIdle);

endmodule
